memory_access_unit: RTL

Memory-stage load/store unit of the 5-stage RV32I pipeline. It sits between the Execute-to-Memory pipeline register and the Memory-to-Writeback register. It turns a decoded load/store into a word-addressed, byte-enabled request/acknowledge bus transaction, and holds the pipeline with a stall until the access completes. Load data is aligned and sign- or zero-extended before it is presented as ReadDataM.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/load_extend.sv | 30 +++
 rtl/memory_access_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // RV32I funct3 access size / sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enable patterns for lane 0; shifted by addr[1:0] for sub-word access
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a read word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by byte offset, then extend according to access type
  always_comb begin
    byte_sel = word[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    result   = word;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: decoded access -> word-addressed req/ack bus transaction.
// Latency: 3 cycles with a zero-wait ack (IDLE, REQ, DONE), +1 per bus wait cycle.
// Backpressure: StallM holds the pipeline from issue until DONE; BusReq waits indefinitely for BusAck.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     MemReadM,
  input  logic                     MemWriteM,
  input  logic [2:0]               Funct3M,
  input  logic [ADDRESS_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0]    WriteDataM,
  output logic [DATA_WIDTH-1:0]    ReadDataM,
  output logic                     StallM,
  output logic                     FaultM,
  output logic                     BusReq,
  output logic                     BusWe,
  output logic [ADDRESS_WIDTH-1:0] BusAddr,
  output logic [3:0]               BusBe,
  output logic [DATA_WIDTH-1:0]    BusWData,
  input  logic [DATA_WIDTH-1:0]    BusRData,
  input  logic                     BusAck
);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [2:0]               f3_q;
  logic                     we_q;
  logic                     req_q;
  logic [3:0]               be_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [DATA_WIDTH-1:0]    load_val;

  logic                     access;
  logic                     bad;
  logic                     go;
  logic [3:0]               be_d;
  logic [DATA_WIDTH-1:0]    wdata_d;

  // Decode size, byte enables, lane-replicated store data and fault conditions
  always_comb begin
    access  = MemReadM | MemWriteM;
    bad     = MemReadM & MemWriteM;
    be_d    = BE_W;
    wdata_d = WriteDataM;
    case (Funct3M)
      F3_B: begin
        be_d    = BE_B << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      F3_H: begin
        be_d    = BE_H << ALUResultM[1:0];
        wdata_d = {2{WriteDataM[15:0]}};
        if (ALUResultM[0]) bad = 1'b1;
      end
      F3_W: begin
        if (ALUResultM[1:0] != 2'b00) bad = 1'b1;
      end
      F3_BU: begin
        be_d = BE_B << ALUResultM[1:0];
        if (MemWriteM) bad = 1'b1;
      end
      F3_HU: begin
        be_d = BE_H << ALUResultM[1:0];
        if (MemWriteM || ALUResultM[0]) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    go = access & ~bad;
  end

  load_extend u_load_extend (
    .word   (BusRData),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .result (load_val)
  );

  // Access FSM with request latches; all bus outputs come straight from registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            addr_q  <= ALUResultM;
            f3_q    <= Funct3M;
            we_q    <= MemWriteM;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (BusAck) begin
            rdata_q <= we_q ? '0 : load_val;
            req_q   <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          // result is only visible for the single advance cycle
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall and fault must act in the issue cycle, so they are decoded from the live inputs
  assign StallM = ~RST & (((state == IDLE) & go) | (state == REQ));
  assign FaultM = ~RST & (state == IDLE) & access & bad;

  assign ReadDataM = rdata_q;
  assign BusReq    = req_q;
  assign BusWe     = we_q;
  assign BusAddr   = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign BusBe     = be_q;
  assign BusWData  = wdata_q;

endmodule
